// File: rtl/pr_elastic.sv
// rtl/pr_elastic.sv - elastic pipeline register with 2-entry skid buffer, stall and flush
// Optional perf counters (bp_cycles, stall_cycles) are enabled by defining PR_ELASTIC_PERF_EN.
module pr_elastic #(
    parameter int WIDTH      = 32,
    parameter bit FLUSH_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PR_ELASTIC_PERF_EN
    ,
    output logic [31:0]      bp_cycles,
    output logic [31:0]      stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             active;
    logic             acc;
    logic             rel;

    // Handshake outputs depend only on state and hazard controls, never on out_ready.
    assign active    = ~i_stall & ~i_flush;
    assign in_ready  = (state_q != ST_FULL) & active;
    assign out_valid = (state_q != ST_EMPTY) & active;
    assign acc       = in_valid & in_ready;
    assign rel       = out_valid & out_ready;
    assign out_data  = main_q;
    assign occupancy = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (i_flush) begin
            state_q <= ST_EMPTY;
            if (FLUSH_ZERO) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else if (!i_stall) begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_q <= ST_ONE;
                        main_q  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (acc && rel) begin
                        main_q <= in_data;
                    end else if (acc) begin
                        state_q <= ST_FULL;
                        skid_q  <= in_data;
                    end else if (rel) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (rel) begin
                        state_q <= ST_ONE;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

`ifdef PR_ELASTIC_PERF_EN
    logic bp_hit;

    assign bp_hit = (state_q != ST_EMPTY) & ~out_ready & active;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_cycles    <= '0;
            stall_cycles <= '0;
        end else begin
            if (bp_hit && (bp_cycles != 32'hFFFF_FFFF)) begin
                bp_cycles <= bp_cycles + 32'd1;
            end
            if (i_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pr_elastic.sv
// tb/tb_pr_elastic.sv - self-checking bench for pr_elastic with a queue reference model
module tb_pr_elastic;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         i_stall;
    logic         i_flush;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;

    logic         in_ready,  nz_in_ready;
    logic         out_valid, nz_out_valid;
    logic [W-1:0] out_data,  nz_out_data;
    logic [1:0]   occupancy, nz_occupancy;
`ifdef PR_ELASTIC_PERF_EN
    logic [31:0]  bp_cycles, stall_cycles, nz_bp_cycles, nz_stall_cycles;
`endif

    int errors = 0;
    int checks = 0;

    pr_elastic #(.WIDTH(W), .FLUSH_ZERO(1'b1)) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
`ifdef PR_ELASTIC_PERF_EN
        , .bp_cycles(bp_cycles), .stall_cycles(stall_cycles)
`endif
    );

    pr_elastic #(.WIDTH(W), .FLUSH_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
        .in_valid(in_valid), .in_ready(nz_in_ready), .in_data(in_data),
        .out_valid(nz_out_valid), .out_ready(out_ready), .out_data(nz_out_data),
        .occupancy(nz_occupancy)
`ifdef PR_ELASTIC_PERF_EN
        , .bp_cycles(nz_bp_cycles), .stall_cycles(nz_stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_stall   = 1'b0;
        i_flush   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
`ifdef PR_ELASTIC_PERF_EN
        checks++; if (bp_cycles !== 32'd0 || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", bp_cycles, stall_cycles);
        end
`endif
    endtask

    task automatic test_streaming;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin
                errors++; $display("FAIL stream_out beat=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, i);
            end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ beat=%0d got=%0d exp=1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] snd [3];
        logic [W-1:0] got [$];
        int idx;
        snd[0] = 32'hA; snd[1] = 32'hB; snd[2] = 32'hC;
        idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            out_ready = !(cyc == 1 || cyc == 2);
            in_valid  = (idx < 3);
            in_data   = (idx < 3) ? snd[idx] : '0;
            #1;
            if (cyc == 2) begin
                checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ got=%0d exp=2", occupancy); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
                checks++; if (out_valid !== 1'b1 || out_data !== 32'hA) begin
                    errors++; $display("FAIL bp_hold got=%b/%h exp=1/a", out_valid, out_data);
                end
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && in_ready) idx++;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (got.size() != 3) begin
            errors++; $display("FAIL bp_count got=%0d exp=3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (got[k] !== snd[k]) begin errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", k, got[k], snd[k]); end
            end
        end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL stall_fill got=%0d exp=2", occupancy); end
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h11) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%h exp=0/0/11", i, out_valid, in_ready, out_data);
            end
            tick();
        end
        i_stall = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin errors++; $display("FAIL stall_rel0 got=%b/%h exp=1/11", out_valid, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h22) begin errors++; $display("FAIL stall_rel1 got=%b/%h exp=1/22", out_valid, out_data); end
        tick();
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stall_drain got=%0d exp=0", occupancy); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h33; tick();
        in_data = 32'h44; tick();
        in_valid = 1'b0;
        i_flush = 1'b1;
        i_stall = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_cycle got=%b/%b exp=0/0", out_valid, in_ready);
        end
        tick();
        i_flush = 1'b0;
        i_stall = 1'b0;
        checks++; if (occupancy !== 2'd0 || nz_occupancy !== 2'd0) begin
            errors++; $display("FAIL flush_occ got=%0d/%0d exp=0/0", occupancy, nz_occupancy);
        end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_zero_data got=%h exp=0", out_data); end
        checks++; if (nz_out_data !== 32'h33) begin errors++; $display("FAIL flush_keep_data got=%h exp=33", nz_out_data); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h55;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_reaccept got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h55 || nz_out_data !== 32'h55) begin
            errors++; $display("FAIL flush_next got=%b/%h/%h exp=1/55/55", out_valid, out_data, nz_out_data);
        end
        tick();
    endtask

`ifdef PR_ELASTIC_PERF_EN
    task automatic test_perf;
        logic [31:0] bp0, st0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h66; tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        bp0 = bp_cycles; st0 = stall_cycles;
        repeat (5) tick();
        i_stall = 1'b1;
        repeat (3) tick();
        i_stall = 1'b0;
        checks++; if (bp_cycles - bp0 !== 32'd5) begin errors++; $display("FAIL perf_bp got=%0d exp=5", bp_cycles - bp0); end
        checks++; if (stall_cycles - st0 !== 32'd3) begin errors++; $display("FAIL perf_stall got=%0d exp=3", stall_cycles - st0); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++; if (bp_cycles - bp0 !== 32'd5 || stall_cycles - st0 !== 32'd3) begin
            errors++; $display("FAIL perf_flush got=%0d/%0d exp=5/3", bp_cycles - bp0, stall_cycles - st0);
        end
    endtask
`endif

    task automatic test_async_reset;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h77; tick();
        in_data = 32'h78; tick();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL async_rst got=%b/%h/%0d exp=0/0/0", out_valid, out_data, occupancy);
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
`ifdef PR_ELASTIC_PERF_EN
        checks++; if (bp_cycles !== 32'd0 || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL async_rst_perf got=%0d/%0d exp=0/0", bp_cycles, stall_cycles);
        end
`endif
        in_valid = 1'b1; in_data = 32'h5;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin
            errors++; $display("FAIL async_rst_first got=%b/%h exp=1/5", out_valid, out_data);
        end
        tick();
    endtask

    // Reference: a FIFO of at most two payloads; flush empties it.
    task automatic test_random;
        logic [W-1:0] q [$];
        logic exp_in_ready, exp_out_valid, hold;
        idle_inputs();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        hold = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            i_stall   = ($urandom_range(0, 9) == 0);
            i_flush   = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if (!hold) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_data  = $urandom;
            end
            #1;
            exp_in_ready  = (q.size() < 2) && !i_stall && !i_flush;
            exp_out_valid = (q.size() > 0) && !i_stall && !i_flush;
            checks++; if (in_ready !== exp_in_ready || out_valid !== exp_out_valid || occupancy !== 2'(q.size())) begin
                errors++; $display("FAIL rand_ctrl cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d",
                    cyc, in_ready, out_valid, occupancy, exp_in_ready, exp_out_valid, q.size());
            end
            checks++; if (nz_in_ready !== exp_in_ready || nz_out_valid !== exp_out_valid || nz_occupancy !== 2'(q.size())) begin
                errors++; $display("FAIL rand_ctrl_nz cyc=%0d got=%b/%b/%0d exp=%b/%b/%0d",
                    cyc, nz_in_ready, nz_out_valid, nz_occupancy, exp_in_ready, exp_out_valid, q.size());
            end
            if (exp_out_valid) begin
                checks++; if (out_data !== q[0] || nz_out_data !== q[0]) begin
                    errors++; $display("FAIL rand_data cyc=%0d got=%h/%h exp=%h", cyc, out_data, nz_out_data, q[0]);
                end
            end
            hold = in_valid && !exp_in_ready;
            if (i_flush) begin
                q.delete();
            end else begin
                if (exp_out_valid && out_ready) void'(q.pop_front());
                if (exp_in_ready && in_valid) q.push_back(in_data);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_streaming();
        test_backpressure();
        test_stall();
        test_flush();
`ifdef PR_ELASTIC_PERF_EN
        test_perf();
`endif
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
